// File: rtl/calc_stack_param.sv
// Parametrised LIFO for the calculator operand/operator stacks with occupancy, full/empty and refusal flags.
// Optional macro CALC_STACK_PEEK2_EN adds second_out (entry below top).
module calc_stack_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push_en,
  input  logic                         pop_en,
  input  logic [WIDTH-1:0]             data_in,
  output logic [WIDTH-1:0]             data_out,
`ifdef CALC_STACK_PEEK2_EN
  output logic [WIDTH-1:0]             second_out,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         is_empty,
  output logic                         is_full,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] top_idx_s;
  logic             empty_s, full_s;

  assign empty_s   = (count_q == {CNT_W{1'b0}});
  assign full_s    = (count_q == CNT_W'(DEPTH));
  assign top_idx_s = IDX_W'(count_q - CNT_W'(1));

  // Next-state: clr beats push/pop; push+pop on a non-empty stack rewrites the top in place.
  always_comb begin
    count_d  = count_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    wr_en_s  = 1'b0;
    wr_idx_s = {IDX_W{1'b0}};
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else begin
      case ({push_en, pop_en})
        2'b10: begin
          if (full_s) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_s  = 1'b1;
            wr_idx_s = IDX_W'(count_q);
            count_d  = count_q + CNT_W'(1);
          end
        end
        2'b01: begin
          if (empty_s) begin
            unf_d = 1'b1;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
        2'b11: begin
          wr_en_s = 1'b1;
          if (empty_s) begin
            wr_idx_s = {IDX_W{1'b0}};
            count_d  = CNT_W'(1);
          end else begin
            wr_idx_s = top_idx_s;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is never reset; entries above count are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_idx_s] <= data_in;
    end
  end

  assign data_out  = empty_s ? {WIDTH{1'b0}} : mem_q[top_idx_s];
  assign count     = count_q;
  assign is_empty  = empty_s;
  assign is_full   = full_s;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef CALC_STACK_PEEK2_EN
  logic [IDX_W-1:0] sec_idx_s;
  assign sec_idx_s  = IDX_W'(count_q - CNT_W'(2));
  assign second_out = (count_q >= CNT_W'(2)) ? mem_q[sec_idx_s] : {WIDTH{1'b0}};
`endif

endmodule
